// File: rtl/nibble_feeder.sv
// nibble_feeder: 4-bit circular FIFO feeding a serializer through a registered
// data/valid pair. The head nibble is prefetched into `data`; each rising edge
// of `ack` consumes the presented nibble and loads the next one.
// Optional build macro NIBBLE_FEEDER_STAT_EN enables saturating overflow and
// underflow event counters; without it ovf_cnt/udf_cnt are tied to zero.
module nibble_feeder #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [3:0]            wr_data,
  input  logic                  ack,
  output logic [3:0]            data,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovf_pulse,
  output logic                  udf_pulse,
  output logic [7:0]            ovf_cnt,
  output logic [7:0]            udf_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_VALID = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic [3:0]            data_reg;
  logic                  ack_d_reg;
  logic                  armed_reg;
  logic                  ovf_pulse_reg, udf_pulse_reg;
  logic [3:0]            mem [DEPTH];

  logic ack_rise;
  logic fifo_nonempty;
  logic fifo_full;
  logic pop;
  logic push;
  logic ovf_next;
  logic udf_next;

  // Request detection; armed_reg blocks a rise until ack has been seen low
  // after reset, so an ack held high across reset release is not a request.
  always_comb begin
    ack_rise      = ack & ~ack_d_reg & armed_reg;
    fifo_nonempty = (count_reg != '0);
    fifo_full     = (count_reg == FULL_CNT);
  end

  // Next-state logic: prefetch when idle, advance on request when presenting.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    udf_next   = 1'b0;
    case (state_reg)
      S_EMPTY: begin
        if (ack_rise) begin
          udf_next = 1'b1;
        end
        if (fifo_nonempty) begin
          pop        = 1'b1;
          state_next = S_VALID;
        end
      end
      S_VALID: begin
        if (ack_rise) begin
          if (fifo_nonempty) begin
            pop = 1'b1;
          end else begin
            state_next = S_EMPTY;
          end
        end
      end
      default: state_next = S_EMPTY;
    endcase
  end

  // Write acceptance: a full FIFO still takes a write when a pop frees a slot.
  always_comb begin
    push       = wr_en & (~fifo_full | pop);
    ovf_next   = wr_en & fifo_full & ~pop;
    count_next = count_reg + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
  end

  // FSM state register.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Pointers, occupancy, presented nibble, request edge tracking and strobes.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      data_reg      <= 4'h0;
      ack_d_reg     <= 1'b0;
      armed_reg     <= 1'b0;
      ovf_pulse_reg <= 1'b0;
      udf_pulse_reg <= 1'b0;
    end else begin
      ack_d_reg     <= ack;
      armed_reg     <= armed_reg | ~ack;
      ovf_pulse_reg <= ovf_next;
      udf_pulse_reg <= udf_next;
      count_reg     <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        data_reg   <= mem[rd_ptr_reg];
      end
    end
  end

  // Storage array; contents are don't-care after reset, so no reset here.
  always_ff @(posedge sclk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

`ifdef NIBBLE_FEEDER_STAT_EN
  logic [7:0] ovf_cnt_reg, udf_cnt_reg;

  // Saturating error counters, advanced in the same edge that raises the strobe.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      ovf_cnt_reg <= 8'h00;
      udf_cnt_reg <= 8'h00;
    end else begin
      if (ovf_next && (ovf_cnt_reg != 8'hFF)) begin
        ovf_cnt_reg <= ovf_cnt_reg + 8'h01;
      end
      if (udf_next && (udf_cnt_reg != 8'hFF)) begin
        udf_cnt_reg <= udf_cnt_reg + 8'h01;
      end
    end
  end

  assign ovf_cnt = ovf_cnt_reg;
  assign udf_cnt = udf_cnt_reg;
`else
  assign ovf_cnt = 8'h00;
  assign udf_cnt = 8'h00;
`endif

  assign data      = data_reg;
  assign valid     = (state_reg == S_VALID);
  assign full      = fifo_full;
  assign empty     = ~fifo_nonempty;
  assign count     = count_reg;
  assign ovf_pulse = ovf_pulse_reg;
  assign udf_pulse = udf_pulse_reg;

endmodule

// File: tb/tb_nibble_feeder.sv
// Testbench for nibble_feeder: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_nibble_feeder;

  logic       sclk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       ack;
  logic [3:0] data;
  logic       valid;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       ovf_pulse;
  logic       udf_pulse;
  logic [7:0] ovf_cnt;
  logic [7:0] udf_cnt;

  nibble_feeder #(.DEPTH_LOG2(3)) dut (
    .sclk      (sclk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .ack       (ack),
    .data      (data),
    .valid     (valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ovf_pulse (ovf_pulse),
    .udf_pulse (udf_pulse),
    .ovf_cnt   (ovf_cnt),
    .udf_cnt   (udf_cnt)
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int fails  = 0;

  // Reference model: FIFO contents as a queue plus the presented nibble.
  logic [3:0] mq[$];
  logic [3:0] m_data;
  bit         m_valid;
  bit         m_ack_d;
  bit         m_armed;
  bit         m_ovf;
  bit         m_udf;
  int         m_ovf_cnt;
  int         m_udf_cnt;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_data    = 4'h0;
    m_valid   = 1'b0;
    m_ack_d   = 1'b0;
    m_armed   = 1'b0;
    m_ovf     = 1'b0;
    m_udf     = 1'b0;
    m_ovf_cnt = 0;
    m_udf_cnt = 0;
  endtask

  // One clock edge of the consumer/producer behaviour.
  task automatic model_edge(input bit w, input logic [3:0] d, input bit a);
    bit rise, consumed, take;
    int pre;
    pre      = mq.size();
    rise     = a && !m_ack_d && m_armed;
    m_udf    = rise && !m_valid;
    consumed = m_valid && rise;
    take     = (!m_valid || consumed) && (pre > 0);
    m_ovf    = w && (pre == 8) && !take;
    if (take) begin
      m_data  = mq.pop_front();
      m_valid = 1'b1;
    end else if (consumed) begin
      m_valid = 1'b0;
    end
    if (w && !m_ovf) mq.push_back(d);
`ifdef NIBBLE_FEEDER_STAT_EN
    if (m_ovf && m_ovf_cnt < 255) m_ovf_cnt++;
    if (m_udf && m_udf_cnt < 255) m_udf_cnt++;
`endif
    if (!a) m_armed = 1'b1;
    m_ack_d = a;
  endtask

  task automatic check_all(input string tag);
    check($sformatf("%s_data", tag),  {4'h0, data}, {4'h0, m_data});
    check($sformatf("%s_valid", tag), {7'h0, valid}, {7'h0, m_valid});
    check($sformatf("%s_count", tag), {4'h0, count}, 8'(mq.size()));
    check($sformatf("%s_full", tag),  {7'h0, full}, {7'h0, (mq.size() == 8)});
    check($sformatf("%s_empty", tag), {7'h0, empty}, {7'h0, (mq.size() == 0)});
    check($sformatf("%s_ovf", tag),   {7'h0, ovf_pulse}, {7'h0, m_ovf});
    check($sformatf("%s_udf", tag),   {7'h0, udf_pulse}, {7'h0, m_udf});
    check($sformatf("%s_ovfcnt", tag), ovf_cnt, 8'(m_ovf_cnt));
    check($sformatf("%s_udfcnt", tag), udf_cnt, 8'(m_udf_cnt));
  endtask

  task automatic step(input bit w, input logic [3:0] d, input bit a);
    wr_en   = w;
    wr_data = d;
    ack     = a;
    @(posedge sclk);
    model_edge(w, d, a);
    #1;
    check_all("step");
  endtask

  task automatic do_reset(input bit a);
    wr_en   = 1'b0;
    wr_data = 4'h0;
    ack     = a;
    rst     = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge sclk);
    #1;
    rst = 1'b1;
  endtask

  logic [3:0] drain_exp [8];
  logic [7:0] exp_udf_cnt;

  initial begin
    bit a_state;
    // Basic prefetch and one request.
    do_reset(1'b0);
    check("rst_empty", {7'h0, empty}, 8'h01);
    check("rst_full",  {7'h0, full},  8'h00);
    step(1'b1, 4'hA, 1'b0);
    check("req32_nobypass", {7'h0, valid}, 8'h00);
    step(1'b1, 4'h5, 1'b0);
    check("req32_data",  {4'h0, data}, 8'h0A);
    check("req32_valid", {7'h0, valid}, 8'h01);
    check("req32_count", {4'h0, count}, 8'h01);
    step(1'b0, 4'h0, 1'b1);
    check("req32_pop_data",  {4'h0, data}, 8'h05);
    check("req32_pop_count", {4'h0, count}, 8'h00);

    // Underflow after the last nibble is consumed.
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b1);
    check("req35_drained", {7'h0, valid}, 8'h00);
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b1);
`ifdef NIBBLE_FEEDER_STAT_EN
    exp_udf_cnt = 8'h01;
`else
    exp_udf_cnt = 8'h00;
`endif
    check("req35_udf",    {7'h0, udf_pulse}, 8'h01);
    check("req35_valid",  {7'h0, valid}, 8'h00);
    check("req35_data",   {4'h0, data}, 8'h05);
    check("req35_udfcnt", udf_cnt, exp_udf_cnt);
    step(1'b0, 4'h0, 1'b0);
    check("req35_udf_once", {7'h0, udf_pulse}, 8'h00);

    // Fill to full, then overflow.
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 4'(i), 1'b0);
    check("req33_full",  {7'h0, full}, 8'h01);
    check("req33_count", {4'h0, count}, 8'h08);
    check("req33_data",  {4'h0, data}, 8'h00);
    check("req33_noovf", {7'h0, ovf_pulse}, 8'h00);
    step(1'b1, 4'h9, 1'b0);
    check("req33_ovf",   {7'h0, ovf_pulse}, 8'h01);
    check("req33_count2", {4'h0, count}, 8'h08);

    // Write while full with simultaneous pop.
    step(1'b1, 4'hA, 1'b1);
    check("req34_count", {4'h0, count}, 8'h08);
    check("req34_data",  {4'h0, data}, 8'h01);
    check("req34_noovf", {7'h0, ovf_pulse}, 8'h00);
    for (int i = 0; i < 7; i++) drain_exp[i] = 4'(i + 2);
    drain_exp[7] = 4'hA;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'h0, 1'b0);
      step(1'b0, 4'h0, 1'b1);
      check($sformatf("req34_order%0d", i), {4'h0, data}, {4'h0, drain_exp[i]});
    end
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b1);
    check("req34_done", {7'h0, valid}, 8'h00);

    // Held ack pops once.
    do_reset(1'b0);
    step(1'b1, 4'hB, 1'b0);
    step(1'b1, 4'hC, 1'b0);
    step(1'b1, 4'hD, 1'b0);
    step(1'b1, 4'hE, 1'b0);
    check("req36_pre", {4'h0, count}, 8'h03);
    for (int i = 0; i < 20; i++) step(1'b0, 4'h0, 1'b1);
    check("req36_data",  {4'h0, data}, 8'h0C);
    check("req36_count", {4'h0, count}, 8'h02);
    step(1'b0, 4'h0, 1'b0);

    // ack high across reset release is not a request.
    do_reset(1'b1);
    step(1'b1, 4'h7, 1'b1);
    check("req29_noudf", {7'h0, udf_pulse}, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1);
    check("req29_valid", {7'h0, valid}, 8'h01);
    check("req29_data",  {4'h0, data}, 8'h07);
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b1);
    check("req29_consumed", {7'h0, valid}, 8'h00);

    // Asynchronous reset between edges with 5 queued.
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 4'(i + 3), 1'b0);
    check("req37_pre", {4'h0, count}, 8'h05);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check("req37_count", {4'h0, count}, 8'h00);
    check("req37_valid", {7'h0, valid}, 8'h00);
    check("req37_data",  {4'h0, data}, 8'h00);
    check_all("req37");
    @(posedge sclk);
    #1;
    rst = 1'b1;
    step(1'b1, 4'h6, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    check("req28_data", {4'h0, data}, 8'h06);

    // Random traffic: write-heavy phase then drain-heavy phase.
    do_reset(1'b0);
    a_state = 1'b0;
    for (int i = 0; i < 800; i++) begin
      bit w;
      w = ($urandom_range(0, 99) < ((i < 400) ? 80 : 30));
      if ($urandom_range(0, 99) < 45) a_state = ~a_state;
      step(w, 4'($urandom), a_state);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/nibble_feeder.md
NIBBLE_FEEDER -- requirements
Module: nibble_feeder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3, log2 of FIFO depth (depth = 8 nibbles).
REQ-002 SHALL have port sclk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wr_en  input  1  write strobe from producer, one nibble per high cycle.
REQ-005 SHALL have port wr_data  input  4  nibble to enqueue.
REQ-006 SHALL have port ack  input  1  data request from downstream serializer, level signal in sclk domain.
REQ-007 SHALL have port data  output  4  registered nibble presented to serializer.
REQ-008 SHALL have port valid  output  1  high while data holds an unconsumed nibble.
REQ-009 SHALL have port full  output  1  FIFO holds DEPTH nibbles.
REQ-010 SHALL have port empty  output  1  FIFO holds 0 nibbles (presented word excluded).
REQ-011 SHALL have port count  output  DEPTH_LOG2+1  FIFO occupancy, presented word excluded.
REQ-012 SHALL have ports ovf_pulse, udf_pulse  output  1 each  one-cycle error strobes.
REQ-013 SHALL have ports ovf_cnt, udf_cnt  output  8 each  error statistics (see Configuration).

Function
REQ-014 SHALL implement a circular FIFO of 2^DEPTH_LOG2 x 4 bits with wrapping read/write pointers; full/empty/count derived from count register.
REQ-015 SHALL detect request as ack_rise = ack & ~ack_d, ack_d being ack registered on sclk.
REQ-016 SHALL implement FSM with states S_EMPTY (valid=0) and S_VALID (valid=1).
REQ-017 S_EMPTY and FIFO non-empty: SHALL pop head into data at that edge and go to S_VALID (prefetch, 1-cycle latency from write to valid when idle).
REQ-018 S_VALID and ack_rise: if FIFO non-empty SHALL pop head into data and stay S_VALID; else SHALL go S_EMPTY, data holds last value.
REQ-019 S_VALID without ack_rise: data and state SHALL hold; ack held high SHALL NOT cause further pops.
REQ-020 ack_rise in S_EMPTY SHALL assert udf_pulse for exactly one cycle; no state change.
REQ-021 wr_en while full and no pop in same cycle SHALL drop wr_data, assert ovf_pulse one cycle.
REQ-022 wr_en while full with simultaneous pop SHALL accept the write; count unchanged.
REQ-023 Simultaneous write and pop at any occupancy SHALL leave count unchanged and preserve order.
REQ-024 Write into empty FIFO in S_EMPTY SHALL NOT bypass: nibble reaches data at the edge after it is written.
REQ-025 Nibbles SHALL exit in strict write order; none duplicated or skipped except dropped overflow writes.

Reset
REQ-026 rst low SHALL immediately clear: pointers, count=0, state=S_EMPTY, data=4'h0, valid=0, ack_d=0, pulses=0, ovf_cnt=udf_cnt=0.
REQ-027 empty=1, full=0 during and after reset; FIFO storage contents need not be cleared.
REQ-028 Reset asserted mid-transfer SHALL discard all queued and presented nibbles; first post-reset write behaves as REQ-017.
REQ-029 ack high at reset release SHALL NOT be treated as a rise until it has been seen low.

Configuration
REQ-030 Macro NIBBLE_FEEDER_STAT_EN defined: ovf_cnt/udf_cnt SHALL increment on each ovf_pulse/udf_pulse, saturating at 8'hFF, cleared only by reset.
REQ-031 Macro undefined: ovf_cnt/udf_cnt SHALL be constant 8'h00, no counter logic; all other behaviour identical.

Verification
REQ-032 Reset, write 4'hA, 4'h5 on consecutive cycles -> data=4'hA valid=1 one cycle after first write; count=1; ack pulse -> data=4'h5, count=0.
REQ-033 Write 9 nibbles 0..8 back-to-back from reset, no ack -> first loaded into data, 8 fill FIFO, full=1 with no overflow; 10th write -> ovf_pulse=1, dropped.
REQ-034 FIFO full, wr_en and ack_rise same cycle -> write accepted, count stays 8, output order intact.
REQ-035 Presented nibble consumed, FIFO empty, second ack_rise -> udf_pulse one cycle, valid=0, data unchanged; with NIBBLE_FEEDER_STAT_EN udf_cnt=1, without 0.
REQ-036 ack held high 20 cycles with 3 nibbles queued -> exactly one pop.
REQ-037 Assert rst low asynchronously between edges with 5 queued -> outputs reset instantly; count=0, valid=0.
